mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-port memory controller sharing the byte-wide RAM between the instruction fetcher and the load/store queue.
- Latches one pending request per requester and arbitrates round-robin.
- Serialises each 1/2/4-byte access into byte beats, assembles read data little-endian, and returns a one-cycle ready pulse.
- Aborts speculative reads on rollback; committed stores always complete.

Parameters:
ADDR_WIDTH, 32, byte address width (RAM and requester addresses)
DATA_WIDTH, 32, requester data width; must be 32

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset), sampled on rising clk
in_rollback  in  1  misprediction flush
in_if_ena  in  1  fetch request pulse (always 4-byte read)
in_if_addr  in  ADDR_WIDTH  fetch byte address
out_if_ready  out  1  one-cycle pulse: out_if_data valid
out_if_data  out  DATA_WIDTH  fetched instruction
in_ls_ena  in  1  LSQ request pulse
in_ls_we  in  1  1 = store, 0 = load
in_ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
in_ls_addr  in  ADDR_WIDTH  LSQ byte address
in_ls_data  in  DATA_WIDTH  store data, low bytes used
out_ls_ready  out  1  one-cycle pulse: load data valid / store done
out_ls_data  out  DATA_WIDTH  load data, zero-extended (LSQ sign-extends)
out_ram_addr  out  ADDR_WIDTH  RAM byte address
out_ram_wr  out  1  RAM write strobe
out_ram_dout  out  8  RAM write byte
in_ram_din  in  8  RAM read byte, 1-cycle latency

Behaviour:
- Reset (rst=0 at an edge):
  - All outputs 0.
  - Pending flags cleared, state IDLE, last_grant = IF.
  - Reset mid-transaction abandons the transaction with no ready pulse.
- Request capture:
  - ena sampled at edge E sets the pending flag and latches addr/size/we/data.
  - ena while the same requester is pending or in service is a protocol violation: ignored, and flagged by a bench assertion.
- FSM states: IDLE, READ, WRITE.
  - IDLE: out_ram_wr=0, out_ram_addr=0.
  - With any pending flag set, IDLE grants at the next edge.
  - Grant rule when both are pending: the requester not granted last; otherwise the sole pending one.
  - Grant clears that requester's pending flag, loads the beat counter k=0, N = 4 (IF) or 1/2/4 (LS), and moves to READ or WRITE.
  - Minimum latency from ena edge to beat 0 is 2 cycles.
- READ, beat cycles k=0..N-1:
  - Drive out_ram_addr=A+k, out_ram_wr=0.
  - Byte k is sampled from in_ram_din at the end of cycle k+1, into bits [8k+7:8k]; unused upper bytes are 0.
  - In cycle N, out_ram_addr=0.
  - Cycle N+1: the ready pulse and data are registered, and the state returns to IDLE.
  - Word read: ready in cycle 5 after grant.
- WRITE, cycles k=0..N-1:
  - Drive out_ram_wr=1, out_ram_addr=A+k, out_ram_dout=in_ls_data byte k.
  - Cycle N: out_ram_wr=0, out_ls_ready=1, state returns to IDLE.
- Ready/data:
  - out_*_ready is high exactly one cycle per completed transaction.
  - out_*_data holds its value until the next completion for that requester.
  - A new grant may occur in the same edge that registers ready: back-to-back with no bubble beyond IDLE's one cycle.
- Address arithmetic: A+k wraps modulo 2^ADDR_WIDTH; no alignment requirement.
- Rollback (in_rollback=1 at an edge):
  - Clears the IF pending flag, and the LS pending flag if that request is a load.
  - Any in-flight READ (IF or LS) is aborted: state returns to IDLE, out_ram_addr=0, no ready pulse.
  - In-flight WRITE continues unaffected; a pending store stays pending.
  - ena arriving in the rollback cycle: IF dropped, LS load dropped, LS store accepted.
  - A ready pulse already on the outputs in the rollback cycle is not retracted.
- Illegal in_ls_size=3: treated as word.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release -> all outputs 0, out_ram_wr never 1 with no requests.
- IF word read at 0x1000, RAM returns bytes 0x13,0x05,0x10,0x00 -> out_ram_addr 0x1000..0x1003 in beat cycles 0..3; out_if_ready one pulse in cycle 5 after grant; out_if_data=0x00100513.
- LS half store 0xABCD1234 at 0x2001 -> out_ram_wr=1 with (0x2001,0x34),(0x2002,0x12); out_ls_ready pulse one cycle after the last beat; no write to 0x2003.
- Simultaneous IF read and LS byte load at 0xFFFFFFFF, last_grant=IF -> LS served first (byte 0x80 gives out_ls_data=0x00000080); IF follows after one IDLE cycle. Fetch wrap check: IF read at 0xFFFFFFFE issues addresses 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1.
- Rollback during IF beat 2 with a store pending -> no out_if_ready; IF pending cleared; store then executes fully with out_ls_ready.
- Rollback during a LS word store beat 1 -> all 4 write beats complete, out_ls_ready pulses; simultaneous in_if_ena dropped (no later fetch beats).

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester / RAM bundle of the single-port memory arbiter.
// The master side is everything around the arbiter (fetcher, LSQ, RAM); the slave side is the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  in_rollback;
  logic                  in_if_ena;
  logic [ADDR_WIDTH-1:0] in_if_addr;
  logic                  out_if_ready;
  logic [DATA_WIDTH-1:0] out_if_data;
  logic                  in_ls_ena;
  logic                  in_ls_we;
  logic [1:0]            in_ls_size;
  logic [ADDR_WIDTH-1:0] in_ls_addr;
  logic [DATA_WIDTH-1:0] in_ls_data;
  logic                  out_ls_ready;
  logic [DATA_WIDTH-1:0] out_ls_data;
  logic [ADDR_WIDTH-1:0] out_ram_addr;
  logic                  out_ram_wr;
  logic [7:0]            out_ram_dout;
  logic [7:0]            in_ram_din;

  modport master (
    output in_rollback, in_if_ena, in_if_addr, in_ls_ena, in_ls_we, in_ls_size,
           in_ls_addr, in_ls_data, in_ram_din,
    input  out_if_ready, out_if_data, out_ls_ready, out_ls_data,
           out_ram_addr, out_ram_wr, out_ram_dout
  );

  modport slave (
    input  in_rollback, in_if_ena, in_if_addr, in_ls_ena, in_ls_we, in_ls_size,
           in_ls_addr, in_ls_data, in_ram_din,
    output out_if_ready, out_if_data, out_ls_ready, out_ls_data,
           out_ram_addr, out_ram_wr, out_ram_dout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a byte-wide single-port RAM between instruction fetch and the LSQ.
// Each access is split into byte beats; read data is assembled little-endian and returned with a ready pulse.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef enum logic       {REQ_IF, REQ_LS}    req_t;

  state_t                state, state_nx;
  req_t                  cur, last_grant;
  logic                  if_pend, ls_pend;
  logic [ADDR_WIDTH-1:0] if_addr_q, ls_addr_q, base;
  logic                  ls_we_q;
  logic [1:0]            ls_size_q;
  logic [DATA_WIDTH-1:0] ls_data_q, wdata, rdata, rdata_nx;
  logic [2:0]            beat, nbeats;
  logic                  if_live, ls_live, grant_if, grant_ls, if_busy, ls_busy;
  logic                  if_ready, ls_ready;
  logic [DATA_WIDTH-1:0] if_data, ls_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_wr;
  logic [7:0]            ram_dout;

  // A rollback edge must never start a read, so pending flags are filtered before arbitration.
  assign if_live  = if_pend & ~bus.in_rollback;
  assign ls_live  = ls_pend & ~(bus.in_rollback & ~ls_we_q);
  assign if_busy  = (state != IDLE) && (cur == REQ_IF);
  assign ls_busy  = (state != IDLE) && (cur == REQ_LS);
  assign rdata_nx = rdata | (DATA_WIDTH'(bus.in_ram_din) << {beat - 3'd1, 3'b000});

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_nx = state;
    grant_if = 1'b0;
    grant_ls = 1'b0;
    ram_addr = '0;
    ram_wr   = 1'b0;
    ram_dout = 8'h00;
    case (state)
      IDLE: begin
        if (if_live && ls_live) begin
          grant_ls = (last_grant == REQ_IF);
          grant_if = (last_grant == REQ_LS);
        end else begin
          grant_if = if_live;
          grant_ls = ls_live;
        end
        if (grant_if)      state_nx = READ;
        else if (grant_ls) state_nx = ls_we_q ? WRITE : READ;
      end
      READ: begin
        if (beat < nbeats) ram_addr = base + ADDR_WIDTH'(beat);
        if (bus.in_rollback || beat == nbeats) state_nx = IDLE;
      end
      WRITE: begin
        ram_wr   = 1'b1;
        ram_addr = base + ADDR_WIDTH'(beat);
        ram_dout = wdata[{beat[1:0], 3'b000} +: 8];
        if (beat == nbeats - 3'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst) begin
      state      <= IDLE;
      cur        <= REQ_IF;
      last_grant <= REQ_IF;
      if_pend    <= 1'b0;
      ls_pend    <= 1'b0;
      if_addr_q  <= '0;
      ls_addr_q  <= '0;
      ls_we_q    <= 1'b0;
      ls_size_q  <= 2'd0;
      ls_data_q  <= '0;
      base       <= '0;
      wdata      <= '0;
      rdata      <= '0;
      beat       <= 3'd0;
      nbeats     <= 3'd0;
      if_ready   <= 1'b0;
      ls_ready   <= 1'b0;
      if_data    <= '0;
      ls_data    <= '0;
    end else begin
      state    <= state_nx;
      if_ready <= 1'b0;
      ls_ready <= 1'b0;

      if (grant_if || bus.in_rollback) begin
        if_pend <= 1'b0;
      end else if (bus.in_if_ena && !if_pend && !if_busy) begin
        if_pend   <= 1'b1;
        if_addr_q <= bus.in_if_addr;
      end

      // Committed stores survive rollback; loads in flight or arriving with it are dropped.
      if (grant_ls) begin
        ls_pend <= 1'b0;
      end else if (ls_pend) begin
        if (bus.in_rollback && !ls_we_q) ls_pend <= 1'b0;
      end else if (bus.in_ls_ena && !ls_busy && (bus.in_ls_we || !bus.in_rollback)) begin
        ls_pend   <= 1'b1;
        ls_addr_q <= bus.in_ls_addr;
        ls_we_q   <= bus.in_ls_we;
        ls_size_q <= bus.in_ls_size;
        ls_data_q <= bus.in_ls_data;
      end

      if (grant_if || grant_ls) begin
        cur        <= grant_if ? REQ_IF : REQ_LS;
        last_grant <= grant_if ? REQ_IF : REQ_LS;
        base       <= grant_if ? if_addr_q : ls_addr_q;
        wdata      <= ls_data_q;
        rdata      <= '0;
        beat       <= 3'd0;
        if (grant_if || ls_size_q[1]) nbeats <= 3'd4;
        else                          nbeats <= ls_size_q[0] ? 3'd2 : 3'd1;
      end

      if (state == READ && !bus.in_rollback) begin
        beat <= beat + 3'd1;
        if (beat != 3'd0) rdata <= rdata_nx;
        if (beat == nbeats) begin
          if (cur == REQ_IF) begin
            if_ready <= 1'b1;
            if_data  <= rdata_nx;
          end else begin
            ls_ready <= 1'b1;
            ls_data  <= rdata_nx;
          end
        end
      end

      if (state == WRITE) begin
        beat <= beat + 3'd1;
        if (beat == nbeats - 3'd1) ls_ready <= 1'b1;
      end
    end
  end

  assign bus.out_if_ready = if_ready;
  assign bus.out_if_data  = if_data;
  assign bus.out_ls_ready = ls_ready;
  assign bus.out_ls_data  = ls_data;
  assign bus.out_ram_addr = ram_addr;
  assign bus.out_ram_wr   = ram_wr;
  assign bus.out_ram_dout = ram_dout;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios, then randomized traffic with rollbacks,
// checked against a byte-address reference model of RAM contents and expected write beats.
module tb_mem_arbiter;
  typedef struct {
    logic [31:0] data;
    logic        we;
    int          t;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  b;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t if_q[$];
  exp_t ls_q[$];
  wr_t  wq[$];
  exp_t e;
  wr_t  w;
  logic [7:0] ram_q;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents: a few fixed bytes, otherwise a hash of the address. Stores are logged, not applied.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_1002: return 8'h10;
      32'h0000_1003: return 8'h00;
      32'hFFFF_FFFF: return 8'h80;
      default: begin
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ a[7:0];
      end
    endcase
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] read_val(input logic [31:0] a, input int n);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ram_byte(a + 32'(k))) << (8 * k));
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 7));
    return $urandom;
  endfunction

  // 1-cycle-latency RAM: address seen in cycle k returns its byte during cycle k+1.
  always @(negedge clk) ram_q = ram_byte(bus.out_ram_addr);
  always @(posedge clk) begin
    #1;
    bus.in_ram_din = ram_q;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.in_if_ena   = 1'b0;
    bus.in_ls_ena   = 1'b0;
    bus.in_rollback = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic issue_if(input logic [31:0] a);
    exp_t x;
    assert (if_q.size() == 0) else $error("protocol violation: fetch request while one is outstanding");
    bus.in_if_ena  = 1'b1;
    bus.in_if_addr = a;
    x.data = read_val(a, 4);
    x.we   = 1'b0;
    x.t    = cyc;
    if_q.push_back(x);
  endtask

  task automatic issue_ls(input logic we, input logic [1:0] size, input logic [31:0] a,
                          input logic [31:0] d);
    exp_t x;
    wr_t  y;
    assert (ls_q.size() == 0) else $error("protocol violation: LSQ request while one is outstanding");
    bus.in_ls_ena  = 1'b1;
    bus.in_ls_we   = we;
    bus.in_ls_size = size;
    bus.in_ls_addr = a;
    bus.in_ls_data = d;
    x.data = we ? 32'h0 : read_val(a, nbytes(size));
    x.we   = we;
    x.t    = cyc;
    ls_q.push_back(x);
    if (we) begin
      for (int k = 0; k < nbytes(size); k++) begin
        y.addr = a + 32'(k);
        y.b    = 8'(d >> (8 * k));
        wq.push_back(y);
      end
    end
  endtask

  // Monitor: consumes whatever the DUT presents and pops the matching expectation.
  always @(negedge clk) begin
    if (bus.out_ram_wr === 1'b1) begin
      if (wq.size() == 0) check("unexpected_ram_wr", 32'(bus.out_ram_wr), 32'd0);
      else begin
        w = wq.pop_front();
        check("wr_addr", bus.out_ram_addr, w.addr);
        check("wr_byte", 32'(bus.out_ram_dout), 32'(w.b));
      end
    end
    if (bus.out_if_ready === 1'b1) begin
      if (if_q.size() == 0) check("unexpected_if_ready", 32'd1, 32'd0);
      else begin
        e = if_q.pop_front();
        check("if_data", bus.out_if_data, e.data);
      end
    end
    if (bus.out_ls_ready === 1'b1) begin
      if (ls_q.size() == 0) check("unexpected_ls_ready", 32'd1, 32'd0);
      else begin
        e = ls_q.pop_front();
        if (e.we) check("store_beats_left", 32'(wq.size()), 32'd0);
        else      check("ls_data", bus.out_ls_data, e.data);
      end
    end
    if (if_q.size() != 0 && cyc - if_q[0].t > 60) begin
      check("if_timeout", 32'(cyc - if_q[0].t), 32'd60);
      void'(if_q.pop_front());
    end
    if (ls_q.size() != 0 && cyc - ls_q[0].t > 60) begin
      check("ls_timeout", 32'(cyc - ls_q[0].t), 32'd60);
      void'(ls_q.pop_front());
    end
    if (bus.in_rollback === 1'b1) begin
      if_q.delete();
      if (ls_q.size() != 0 && !ls_q[0].we) ls_q.delete();
    end
    if (rst === 1'b0) begin
      if_q.delete();
      ls_q.delete();
      wq.delete();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_rollback = 1'b0;
    bus.in_if_ena   = 1'b0;
    bus.in_if_addr  = '0;
    bus.in_ls_ena   = 1'b0;
    bus.in_ls_we    = 1'b0;
    bus.in_ls_size  = 2'd0;
    bus.in_ls_addr  = '0;
    bus.in_ls_data  = '0;
    bus.in_ram_din  = 8'h00;

    // Reset, then idle with no requests.
    rst = 1'b0;
    wait_cycles(3);
    rst = 1'b1;
    step();
    check("rst_if_ready", 32'(bus.out_if_ready), 32'd0);
    check("rst_ls_ready", 32'(bus.out_ls_ready), 32'd0);
    check("rst_if_data", bus.out_if_data, 32'd0);
    check("rst_ls_data", bus.out_ls_data, 32'd0);
    check("rst_ram_addr", bus.out_ram_addr, 32'd0);
    check("rst_ram_wr", 32'(bus.out_ram_wr), 32'd0);
    check("rst_ram_dout", 32'(bus.out_ram_dout), 32'd0);
    wait_cycles(4);

    // Fetch word at 0x1000.
    issue_if(32'h0000_1000);
    wait_cycles(2);
    for (int k = 0; k < 4; k++) begin
      check("if_beat_addr", bus.out_ram_addr, 32'h0000_1000 + 32'(k));
      check("if_beat_wr", 32'(bus.out_ram_wr), 32'd0);
      step();
    end
    check("read_tail_addr", bus.out_ram_addr, 32'd0);
    step();
    check("if_ready_pulse", 32'(bus.out_if_ready), 32'd1);
    check("if_word", bus.out_if_data, 32'h0010_0513);
    step();
    check("if_ready_low", 32'(bus.out_if_ready), 32'd0);
    check("if_data_held", bus.out_if_data, 32'h0010_0513);
    wait_cycles(2);

    // Simultaneous fetch and byte load with last grant = fetch: load goes first.
    issue_if(32'h0000_1000);
    issue_ls(1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0);
    wait_cycles(2);
    check("ls_first_addr", bus.out_ram_addr, 32'hFFFF_FFFF);
    step();
    check("ls_tail_addr", bus.out_ram_addr, 32'd0);
    step();
    check("ls_ready_pulse", 32'(bus.out_ls_ready), 32'd1);
    check("ls_byte", bus.out_ls_data, 32'h0000_0080);
    check("idle_gap_addr", bus.out_ram_addr, 32'd0);
    step();
    check("if_second_addr", bus.out_ram_addr, 32'h0000_1000);
    wait_cycles(8);

    // Half-word store, unaligned.
    issue_ls(1'b1, 2'd1, 32'h0000_2001, 32'hABCD_1234);
    wait_cycles(2);
    check("st_b0_wr", 32'(bus.out_ram_wr), 32'd1);
    check("st_b0_addr", bus.out_ram_addr, 32'h0000_2001);
    check("st_b0_byte", 32'(bus.out_ram_dout), 32'h34);
    step();
    check("st_b1_addr", bus.out_ram_addr, 32'h0000_2002);
    check("st_b1_byte", 32'(bus.out_ram_dout), 32'h12);
    step();
    check("st_done_wr", 32'(bus.out_ram_wr), 32'd0);
    check("st_ready", 32'(bus.out_ls_ready), 32'd1);
    step();
    check("st_no_third", 32'(bus.out_ram_wr), 32'd0);
    wait_cycles(2);

    // Fetch wrapping past the top of the address space.
    issue_if(32'hFFFF_FFFE);
    wait_cycles(2);
    check("wrap_a0", bus.out_ram_addr, 32'hFFFF_FFFE);
    step();
    check("wrap_a1", bus.out_ram_addr, 32'hFFFF_FFFF);
    step();
    check("wrap_a2", bus.out_ram_addr, 32'h0000_0000);
    step();
    check("wrap_a3", bus.out_ram_addr, 32'h0000_0001);
    wait_cycles(4);

    // Rollback during fetch beat 2 with a store pending.
    issue_if(32'h0000_4000);
    step();
    issue_ls(1'b1, 2'd2, 32'h0000_3000, 32'hDEAD_BEEF);
    wait_cycles(3);
    check("rb_if_beat2", bus.out_ram_addr, 32'h0000_4002);
    bus.in_rollback = 1'b1;
    step();
    check("rb_abort_addr", bus.out_ram_addr, 32'd0);
    check("rb_abort_wr", 32'(bus.out_ram_wr), 32'd0);
    step();
    check("rb_st_wr", 32'(bus.out_ram_wr), 32'd1);
    check("rb_st_addr", bus.out_ram_addr, 32'h0000_3000);
    check("rb_st_byte", 32'(bus.out_ram_dout), 32'hEF);
    wait_cycles(4);
    check("rb_st_ready", 32'(bus.out_ls_ready), 32'd1);
    wait_cycles(2);

    // Rollback during store beat 1, fetch arriving in the same cycle is dropped.
    issue_ls(1'b1, 2'd2, 32'h0000_5000, 32'h0102_0304);
    wait_cycles(3);
    bus.in_rollback = 1'b1;
    issue_if(32'h0000_7000);
    check("rb2_b1_addr", bus.out_ram_addr, 32'h0000_5001);
    step();
    check("rb2_b2_wr", 32'(bus.out_ram_wr), 32'd1);
    step();
    check("rb2_b3_addr", bus.out_ram_addr, 32'h0000_5003);
    step();
    check("rb2_ready", 32'(bus.out_ls_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rb2_no_fetch", bus.out_ram_addr, 32'd0);
    end

    // Randomized traffic with occasional rollbacks.
    for (int i = 0; i < 1500; i++) begin
      step();
      if ($urandom_range(0, 15) == 0) bus.in_rollback = 1'b1;
      if (if_q.size() == 0 && $urandom_range(0, 2) == 0) issue_if(rand_addr());
      if (ls_q.size() == 0 && $urandom_range(0, 2) == 0)
        issue_ls(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_addr(), $urandom);
    end
    for (int i = 0; i < 200 && (if_q.size() + ls_q.size() + wq.size()) != 0; i++) step();
    check("drain_if", 32'(if_q.size()), 32'd0);
    check("drain_ls", 32'(ls_q.size()), 32'd0);
    check("drain_wr", 32'(wq.size()), 32'd0);

    // Reset in the middle of a fetch abandons it silently.
    wait_cycles(2);
    issue_if(32'h0000_6000);
    wait_cycles(3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_addr", bus.out_ram_addr, 32'd0);
    check("mid_rst_if_data", bus.out_if_data, 32'd0);
    wait_cycles(10);
    check("mid_rst_idle", bus.out_ram_addr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
